mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline stage 4 (memory access) of the 5-stage RV32I core. Sits between the EX/MEM register and write-back: consumes the execute result, performs byte/half/word loads and stores against a handshaked data memory, formats load data, and presents a registered write-back record (RegWrite, rd, data). It stalls the execute side while a memory access is outstanding.

## Interface
- XLEN, 32: datapath and address width. Only 32 is supported.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM entry present this cycle.
- ex_ready  out  1  stage can accept an entry. Transfer occurs when ex_valid && ex_ready at a rising edge.
- ex_alu_out  in  XLEN  ALU result; byte address for memory ops.
- ex_store_data  in  XLEN  forwarded rs2 value for stores.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  entry writes rd.
- ex_mem_read  in  1  entry is a load.
- ex_mem_write  in  1  entry is a store. Never both read and write.
- ex_funct3  in  3  access size/sign.
- dmem_req  out  1  memory request; held until ack.
- dmem_wen  out  1  1 = write, 0 = read; valid while dmem_req.
- dmem_addr  out  XLEN  word address, bits [1:0] always 0.
- dmem_be  out  4  byte enables (writes; 4'b1111 on reads).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rdata  in  XLEN  read data, valid when dmem_ack.
- dmem_ack  in  1  access complete, sampled at rising edge.
- wb_valid  out  1  one-cycle pulse per retired entry.
- wb_reg_write  out  1  write rd this pulse.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  ALU result or formatted load data.
- mem_fault  out  1  one-cycle pulse with wb_valid for misaligned/illegal access.

## Operation
- States: IDLE, ACCESS. Reset → IDLE.
- IDLE, ex_ready = 1. On transfer:
  - Non-memory entry: wb_* loaded next edge (wb_data = ex_alu_out); stay IDLE.
  - Memory entry, legal and aligned: latch address, size, data, rd; → ACCESS.
  - Memory entry, misaligned or illegal funct3: no dmem access; wb_valid = 1, wb_reg_write = 0, mem_fault = 1 next cycle; stay IDLE.
- ACCESS: ex_ready = 0, dmem_req = 1 with all dmem_* stable. On dmem_ack: retire (wb_valid pulse next cycle), → IDLE.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Others illegal.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0.
- Stores: SB be = 1 << addr[1:0], wdata = {4{byte}}; SH be = addr[1] ? 1100 : 0011, wdata = {2{half}}; SW be = 1111.
- Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores retire with wb_reg_write = 0. Any entry with rd = 0 retires with wb_reg_write = 0.

## Timing
- Reset values: ex_ready 1 (after reset release), dmem_req 0, dmem_wen 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, wb_valid 0, wb_reg_write 0, wb_rd 0, wb_data 0, mem_fault 0.
- All outputs registered except ex_ready (decoded from state).
- Non-memory: transfer at edge N → wb_valid in cycle N+1; throughput 1/cycle.
- Memory: transfer at edge N → dmem_req high from cycle N+1; ack sampled at edge M ≥ N+1 → wb_valid in cycle M+1, ex_ready high from cycle M+1. Minimum 2 cycles per memory op.
- dmem_ack while IDLE ignored. dmem_req deasserts in the cycle after ack.
- rst asserted mid-ACCESS: dmem_req drops immediately, access abandoned, no wb_valid; late ack ignored.
- No back-pressure from write-back; wb_valid is never held.

## Structure
- Shared package cpu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum mem_state_t, XLEN.
- Sub-module load_format: combinational lane select + sign/zero-extend (rdata, addr[1:0], funct3 → XLEN).

## Test plan
- Non-memory stream: 3 back-to-back entries rd = 5,6,7, alu_out 0x11, 0x22, 0x33 → wb_valid on 3 consecutive cycles with matching rd/data; ex_ready stays 1.
- SB to 0x1003, data 0x000000A5 → dmem_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5, wen 1; retire with wb_reg_write 0.
- LB from 0x2002, rdata 0x0080FF00, ack after 3 wait cycles → ex_ready 0 for 4 cycles, wb_data 0xFFFFFF80; LBU same → 0x00000080.
- LW from 0x3002 → no dmem_req, wb_valid 1, wb_reg_write 0, mem_fault 1.
- LW rd = 0 from 0x4000, rdata 0xDEADBEEF → wb_valid 1, wb_reg_write 0.
- rst asserted during ACCESS, ack 2 cycles later → dmem_req 0 immediately, no wb_valid, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: widths, load/store funct3 codes, MEM-stage states.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // True when funct3 names a real access of this direction and the address is naturally aligned.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    case (f3)
      F3_B:    access_legal = 1'b1;
      F3_H:    access_legal = !addr_lo[0];
      F3_W:    access_legal = (addr_lo == 2'b00);
      F3_BU:   access_legal = !is_store;
      F3_HU:   access_legal = !is_store && !addr_lo[0];
      default: access_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_format.sv
// Load data formatting: pick the addressed byte/half lane and sign- or zero-extend it.
module load_format
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data = {24'b0, lane[7:0]};
      F3_HU:   data = {16'b0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: handshaked data-memory access, load formatting and registered write-back record.
//   state  | meaning
//   IDLE   | accepting entries; non-memory and faulting entries retire in one cycle
//   ACCESS | dmem_req held with stable address/data until dmem_ack
module mem_access_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_fault
);

  mem_state_t state, state_next;

  logic            xfer, is_mem, legal;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] acc_alu;
  logic [2:0]      acc_f3;
  logic [4:0]      acc_rd;
  logic            acc_rw, acc_load;
  logic [XLEN-1:0] load_data;

  assign ex_ready = (state == IDLE);
  assign xfer     = ex_valid && ex_ready;
  assign is_mem   = ex_mem_read || ex_mem_write;
  assign legal    = access_legal(ex_mem_write, ex_funct3, ex_alu_out[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer && is_mem && legal) state_next = ACCESS;
      ACCESS:  if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reads always enable all four lanes; stores replicate the datum across the word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_store_data;
    if (ex_mem_write) begin
      case (ex_funct3)
        F3_B: begin
          st_be    = 4'b0001 << ex_alu_out[1:0];
          st_wdata = {4{ex_store_data[7:0]}};
        end
        F3_H: begin
          st_be    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_format u_load_format (
    .rdata   (dmem_rdata),
    .addr_lo (acc_alu[1:0]),
    .funct3  (acc_f3),
    .data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_wen     <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_fault    <= 1'b0;
      acc_alu      <= '0;
      acc_f3       <= '0;
      acc_rd       <= '0;
      acc_rw       <= 1'b0;
      acc_load     <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (is_mem && legal) begin
              dmem_req   <= 1'b1;
              dmem_wen   <= ex_mem_write;
              dmem_addr  <= {ex_alu_out[XLEN-1:2], 2'b00};
              dmem_be    <= st_be;
              dmem_wdata <= st_wdata;
              acc_alu    <= ex_alu_out;
              acc_f3     <= ex_funct3;
              acc_rd     <= ex_rd;
              acc_rw     <= ex_mem_read && ex_reg_write && (ex_rd != 5'd0);
              acc_load   <= ex_mem_read;
            end else begin
              // Faulting accesses never touch memory and never write rd.
              wb_valid     <= 1'b1;
              wb_reg_write <= !is_mem && ex_reg_write && (ex_rd != 5'd0);
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_out;
              mem_fault    <= is_mem;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= acc_rw;
            wb_rd        <= acc_rd;
            wb_data      <= acc_load ? load_data : acc_alu;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops vs. a reference model.
module tb_mem_access_stage;

  logic        clk, rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req, dmem_wen;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  int checks = 0;
  int failures = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    byte         b;
    shortint     h;
    sh = rdat >> (8 * off);
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    return 32'(int'(b));
      3'd1:    return 32'(int'(h));
      3'd4:    return {24'b0, sh[7:0]};
      3'd5:    return {16'b0, sh[15:0]};
      default: return rdat;
    endcase
  endfunction

  task automatic run_op(input bit rw, input bit mr, input bit mw, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] rdat, input int w);
    bit          memop, ok;
    int          n, busy;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    memop = mr || mw;
    ok    = model_legal(mw, f3, alu);
    n     = 1 << f3[1:0];
    ex_valid = 1'b1; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_funct3 = f3; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
    chk("ready_idle", ex_ready, 1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (!memop || !ok) begin
      chk("wb_valid", wb_valid, 1);
      chk("mem_fault", mem_fault, memop);
      chk("no_req", dmem_req, 0);
      chk("wb_rd", wb_rd, rd);
      chk("wb_reg_write", wb_reg_write, !memop && rw && rd != 5'd0);
      if (!memop) chk("wb_data_alu", wb_data, alu);
    end else begin
      be_e = mw ? 4'(((1 << n) - 1) << alu[1:0]) : 4'hF;
      for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = sd[8*(i % n) +: 8];
      busy = 0;
      for (int i = 0; i <= w; i++) begin
        chk("req_held", dmem_req, 1);
        chk("wen", dmem_wen, mw);
        chk("addr", dmem_addr, {alu[31:2], 2'b00});
        chk("be", dmem_be, be_e);
        if (mw) chk("wdata", dmem_wdata, wd_e);
        chk("wb_quiet", wb_valid, 0);
        if (ex_ready == 1'b0) busy++;
        if (i == w) begin dmem_ack = 1'b1; dmem_rdata = rdat; end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      chk("busy_cycles", busy, w + 1);
      chk("wb_valid_mem", wb_valid, 1);
      chk("fault_mem", mem_fault, 0);
      chk("req_drop", dmem_req, 0);
      chk("ready_back", ex_ready, 1);
      chk("wb_rd_mem", wb_rd, rd);
      chk("wb_reg_write_mem", wb_reg_write, mr && rw && rd != 5'd0);
      if (mr) chk("wb_load_data", wb_data, model_load(rdat, alu[1:0], f3));
    end
  endtask

  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);   chk("rst_wen", dmem_wen, 0);
    chk("rst_addr", dmem_addr, 0); chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_rw", wb_reg_write, 0);
    chk("rst_wb_rd", wb_rd, 0);       chk("rst_wb_data", wb_data, 0);
    chk("rst_fault", mem_fault, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", ex_ready, 1);

    // Back-to-back non-memory entries retire on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
      ex_rd = 5'(5 + i); ex_alu_out = 32'h11 * (i + 1);
      chk("burst_ready", ex_ready, 1);
      @(posedge clk); #1;
      chk("burst_valid", wb_valid, 1);
      chk("burst_rd", wb_rd, 5'(5 + i));
      chk("burst_data", wb_data, 32'h11 * (i + 1));
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("burst_end", wb_valid, 0);

    run_op(1'b0, 1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 5'd9, 32'h0, 1);
    run_op(1'b1, 1'b1, 1'b0, 3'd0, 32'h2002, 32'h0, 5'd10, 32'h0080_FF00, 3);
    chk("lb_value", wb_data, 32'hFFFF_FF80);
    run_op(1'b1, 1'b1, 1'b0, 3'd4, 32'h2002, 32'h0, 5'd11, 32'h0080_FF00, 3);
    chk("lbu_value", wb_data, 32'h0000_0080);
    run_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h3002, 32'h0, 5'd12, 32'h0, 0);
    run_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 5'd0, 32'hDEAD_BEEF, 0);
    chk("lw_rd0_rw", wb_reg_write, 0);

    for (int k = 0; k < 300; k++) begin
      int          kind, g, w;
      logic [2:0]  f3;
      logic [31:0] alu;
      kind = $urandom_range(0, 2);
      f3   = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      alu  = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      w = $urandom_range(0, 3);
      run_op(1'($urandom), kind == 1, kind == 2, f3, alu, $urandom, 5'($urandom), $urandom, w);
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        dmem_ack = 1'($urandom);
        @(posedge clk); #1;
        chk("gap_wb", wb_valid, 0);
        chk("gap_req", dmem_req, 0);
      end
      dmem_ack = 1'b0;
    end

    // Reset in the middle of an access abandons it; a late ack is ignored.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    ex_funct3 = 3'd2; ex_alu_out = 32'h5000; ex_rd = 5'd3;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("pre_rst_req", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_async_req", dmem_req, 0);
    chk("rst_async_ready", ex_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("late_ack_wb", wb_valid, 0);
      chk("late_ack_req", dmem_req, 0);
      chk("late_ack_ready", ex_ready, 1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
